// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the arithmetic library.
//   FP32_BIAS, FP32_QNAN and field widths
//   fp32_class_t and fp32_classify(): operand class, with exponent field 0
//     (zero or subnormal) reported as ZERO so inputs are flushed to zero
//   div_state_t: control states of the iterative divider
package fp32_pkg;

  localparam int          FP32_BIAS   = 127;
  localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;
  localparam int          FP32_EXP_W  = 8;
  localparam int          FP32_FRAC_W = 23;
  localparam int          FP32_MAN_W  = FP32_FRAC_W + 1;
  // Quotient bits produced by the divider: one integer bit plus 25 fraction bits
  localparam int          FP32_QUO_W  = 26;
  // Exponent arithmetic width, signed, enough for -128..382
  localparam int          FP32_EXPC_W = 10;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp32_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_DONE
  } div_state_t;

  function automatic fp32_class_t fp32_classify(input logic [31:0] x);
    fp32_class_t c;
    if (x[30:23] == 8'd0)
      c = ZERO;
    else if (x[30:23] == 8'hFF)
      c = (x[22:0] == 23'd0) ? INF : NAN;
    else
      c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/restoring_divider_unsigned.sv
// Radix-2 restoring divider, one quotient bit per clock.
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   start_i            load dividend_i/divisor_i; WIDTH iterations follow
//   dividend_i         must be below 2*divisor_i, and divisor_i below
//                      2^(WIDTH-1), so the quotient fits WIDTH bits and the
//                      partial remainder never overflows
//   done_o             high in the cycle whose closing edge performs the
//                      final iteration; quotient_o/rem_nz_o are final after it
//   quotient_o         floor(dividend * 2^(WIDTH-1) / divisor)
//   rem_nz_o           remainder of that division is nonzero
module restoring_divider_unsigned
  import fp32_pkg::*;
#(
  parameter int WIDTH = FP32_QUO_W
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             rem_nz_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, div_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic             ge_d;
  logic [WIDTH-1:0] rem_sel_d;

  always_comb begin
    ge_d      = (rem_q >= div_q);
    rem_sel_d = ge_d ? (rem_q - div_q) : rem_q;
  end

  // rem_q holds twice the true partial remainder, ready for the next compare
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= dividend_i;
      div_q  <= divisor_i;
      quo_q  <= '0;
      cnt_q  <= CNT_W'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= {rem_sel_d[WIDTH-2:0], 1'b0};
      quo_q <= {quo_q[WIDTH-2:0], ge_d};
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1))
        busy_q <= 1'b0;
    end
  end

  assign done_o     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient_o = quo_q;
  assign rem_nz_o   = |rem_q;

endmodule

// File: rtl/fp32_divider.sv
// Iterative IEEE-754 single-precision divider, result_o = A / B.
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   valid_i, A, B   request and operands, sampled only while busy_o = 0
//   result_o        quotient, held until the next done_o
//   done_o          one-cycle pulse, 27 cycles after the accepting edge
//   busy_o          operation in flight, further requests are dropped
//   overflow_o, underflow_o, invalid_o, divzero_o
//                   status, asserted only in the done_o cycle
// Subnormal inputs are flushed to zero; NaN results are the canonical QNaN.
// Build option FP32_DIV_RNE_EN: round to nearest even (default truncates).
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        valid_i,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_o,
  output logic        divzero_o
);

  div_state_t                     state_q;
  logic                           sign_q;
  logic signed [FP32_EXPC_W-1:0]  exp_q;
  fp32_class_t                    cls_a_q, cls_b_q;
  logic [31:0]                    result_q;
  logic                           done_q, ovf_q, unf_q, inv_q, dz_q;

  logic                           start;
  logic                           div_done;
  logic [FP32_QUO_W-1:0]          quo;
  logic                           rem_nz;
  logic signed [FP32_EXPC_W-1:0]  exp_acc;

  assign start   = (state_q == S_IDLE) && valid_i;
  assign exp_acc = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]})
                 + 10'sd127;

  restoring_divider_unsigned #(
    .WIDTH (FP32_QUO_W)
  ) u_mant_div (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .start_i    (start),
    .dividend_i ({2'b01, A[22:0]}),
    .divisor_i  ({2'b01, B[22:0]}),
    .done_o     (div_done),
    .quotient_o (quo),
    .rem_nz_o   (rem_nz)
  );

  // Normalisation, rounding, range checks and special-case override
  logic [FP32_FRAC_W-1:0]         man;
  logic                           g, st, rup;
  logic [FP32_MAN_W-1:0]          man_r;
  logic [FP32_FRAC_W-1:0]         man_f;
  logic signed [FP32_EXPC_W-1:0]  e_n, e_f;
  logic [31:0]                    res_d;
  logic                           ovf_d, unf_d, inv_d, dz_d;

  always_comb begin
    // Quotient lies in (2^24, 2^26): the top bit picks the binary point
    if (quo[25]) begin
      man = quo[24:2];
      g   = quo[1];
      st  = quo[0] | rem_nz;
      e_n = exp_q;
    end else begin
      man = quo[23:1];
      g   = quo[0];
      st  = rem_nz;
      e_n = exp_q - 10'sd1;
    end
`ifdef FP32_DIV_RNE_EN
    rup = g & (st | man[0]);
`else
    rup = 1'b0;
`endif
    man_r = {1'b0, man} + {{FP32_FRAC_W{1'b0}}, rup};
    if (man_r[FP32_FRAC_W]) begin
      man_f = '0;
      e_f   = e_n + 10'sd1;
    end else begin
      man_f = man_r[FP32_FRAC_W-1:0];
      e_f   = e_n;
    end

    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    dz_d  = 1'b0;
    if (cls_a_q == NAN || cls_b_q == NAN ||
        (cls_a_q == ZERO && cls_b_q == ZERO) ||
        (cls_a_q == INF && cls_b_q == INF)) begin
      res_d = FP32_QNAN;
      inv_d = 1'b1;
    end else if (cls_b_q == ZERO && cls_a_q == NORMAL) begin
      res_d = {sign_q, 8'hFF, 23'd0};
      dz_d  = 1'b1;
    end else if (cls_a_q == INF) begin
      res_d = {sign_q, 8'hFF, 23'd0};
    end else if (cls_a_q == ZERO || cls_b_q == INF) begin
      res_d = '0;
    end else if (e_f >= 10'sd255) begin
      res_d = {sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else if (e_f <= 10'sd0) begin
      res_d = '0;
      unf_d = 1'b1;
    end else begin
      res_d = {sign_q, e_f[7:0], man_f};
    end
  end

`ifndef FP32_DIV_RNE_EN
  // Guard and sticky only matter when rounding to nearest
  logic round_bits_unused;
  assign round_bits_unused = g ^ st;
`endif

  // Control FSM; done_o and flags default low so they pulse for one cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cls_a_q  <= ZERO;
      cls_b_q  <= ZERO;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inv_q  <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            sign_q  <= A[31] ^ B[31];
            exp_q   <= exp_acc;
            cls_a_q <= fp32_classify(A);
            cls_b_q <= fp32_classify(B);
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_done)
            state_q <= S_NORM;
        end
        S_NORM: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          inv_q    <= inv_d;
          dz_q     <= dz_d;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign invalid_o   = inv_q;
  assign divzero_o   = dz_q;

endmodule

// File: tb/tb_fp32_divider.sv
// Bench for fp32_divider: directed vectors with literal expectations, plus a
// behavioural model (integer division of the significands) compared against
// the DUT outputs on every falling clock edge.
module tb_fp32_divider;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] result_o;
  logic        done_o, busy_o, overflow_o, underflow_o, invalid_o, divzero_o;

  int n_pass = 0;
  int n_total = 0;

  fp32_divider dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .valid_i     (valid_i),
    .A           (A),
    .B           (B),
    .result_o    (result_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .invalid_o   (invalid_o),
    .divzero_o   (divzero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
  endtask

  // Returns {overflow, underflow, invalid, divzero, result}
  function automatic logic [35:0] model_div(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e;
    longint ma, mb, num, q, r, man;
    bit     s, g, st, rup;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0] e8;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      return {4'b0010, 32'h7FC00000};
    if (b_zero && !a_inf) return {4'b0001, s, 31'h7F800000};
    if (a_inf) return {4'b0000, s, 31'h7F800000};
    if (a_zero || b_inf) return 36'h0;
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    num = ma * 33554432;
    q   = num / mb;
    r   = num % mb;
    e   = ea - eb + 127;
    if (q >= 33554432) begin
      man = (q / 4) % 8388608;
      g   = ((q / 2) % 2) != 0;
      st  = ((q % 2) != 0) || (r != 0);
    end else begin
      man = (q / 2) % 8388608;
      g   = (q % 2) != 0;
      st  = (r != 0);
      e   = e - 1;
    end
`ifdef FP32_DIV_RNE_EN
    rup = g && (st || ((man % 2) != 0));
`else
    rup = g && st && 1'b0;
`endif
    man = man + longint'(rup);
    if (man == 8388608) begin
      man = 0;
      e   = e + 1;
    end
    if (e >= 255) return {4'b1000, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0100, 32'h0};
    e8 = e[7:0];
    return {4'b0000, s, e8, man[22:0]};
  endfunction

  // Model timing: accept when idle, done after 27 more edges, idle one later
  logic [5:0]  m_cnt = '0;
  logic [35:0] m_pend = '0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_fl = '0;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_cnt  <= '0;
      m_pend <= '0;
      m_res  <= '0;
      m_fl   <= '0;
    end else if (m_cnt == 0) begin
      if (valid_i) begin
        m_cnt  <= 6'd1;
        m_pend <= model_div(A, B);
      end
    end else if (m_cnt == 27) begin
      m_cnt <= 6'd28;
      m_res <= m_pend[31:0];
      m_fl  <= m_pend[35:32];
    end else if (m_cnt == 28) begin
      m_cnt <= '0;
      m_fl  <= '0;
    end else begin
      m_cnt <= m_cnt + 6'd1;
    end
  end

  always @(negedge clk_i) begin
    chk("cycle", {26'd0, busy_o, done_o, overflow_o, underflow_o, invalid_o, divzero_o, result_o},
                 {26'd0, (m_cnt != 0), (m_cnt == 28), m_fl, m_res});
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl,
                        input string nm, input bit hold,
                        input logic [31:0] a2, input logic [31:0] b2);
    int lat;
    bit busy_ok, got;
    @(negedge clk_i);
    A = a; B = b; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    if (hold) begin A = a2; B = b2; end
    else valid_i = 1'b0;
    lat = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (done_o) got = 1'b1;
      else if (!busy_o) busy_ok = 1'b0;
    end
    valid_i = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd27);
    chk({nm, " busy"}, 64'(busy_ok), 64'd1);
    chk({nm, " result"}, 64'(result_o), 64'(exp_res));
    chk({nm, " flags"}, 64'({overflow_o, underflow_o, invalid_o, divzero_o}), 64'(exp_fl));
    chk({nm, " model"}, 64'({m_fl, m_res}), 64'({exp_fl, exp_res}));
  endtask

  initial begin
    int  ndone, first, second;
    bit  saw;
    logic [31:0] third_res;
    #1 rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset outputs", 64'({busy_o, done_o, overflow_o, underflow_o, invalid_o, divzero_o, result_o}), 64'd0);
    #2 rstn_i = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "6/2", 1'b0, 0, 0);
`ifdef FP32_DIV_RNE_EN
    third_res = 32'h3EAAAAAB;
`else
    third_res = 32'h3EAAAAAA;
`endif
    run_op(32'h3F800000, 32'h40400000, third_res,    4'b0000, "1/3", 1'b0, 0, 0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, "1/0", 1'b0, 0, 0);
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, "-1/0", 1'b0, 0, 0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010, "0/0", 1'b0, 0, 0);
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0010, "inf/inf", 1'b0, 0, 0);
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, "overflow", 1'b0, 0, 0);
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, "underflow", 1'b0, 0, 0);
    run_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, "subnormal", 1'b0, 0, 0);
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, "-6/2 hold", 1'b1,
           32'h3F800000, 32'h00000000);

    // Continuous request: one accept every 29 cycles
    @(negedge clk_i);
    A = 32'h40C00000; B = 32'h40000000; valid_i = 1'b1;
    ndone = 0; first = -1; second = -1;
    for (int c = 0; c < 95; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (done_o) begin
        if (ndone == 0) first = c;
        else if (ndone == 1) second = c;
        ndone++;
      end
    end
    valid_i = 1'b0;
    chk("stream done count", 64'(ndone), 64'd3);
    chk("stream first done", 64'(first), 64'd27);
    chk("stream interval", 64'(second - first), 64'd29);
    repeat (40) @(negedge clk_i);

    // Reset during iteration 10 aborts the operation
    A = 32'h3F800000; B = 32'h40400000; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1 chk("abort outputs", 64'({busy_o, done_o, overflow_o, underflow_o, invalid_o, divzero_o, result_o}), 64'd0);
    @(negedge clk_i);
    #2 rstn_i = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) saw = 1'b1;
    end
    chk("no done after abort", 64'(saw), 64'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "after abort", 1'b0, 0, 0);

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
